// File: rtl/ahb5_excl_monitor_if.sv
// ahb5_excl_monitor_if
//   Bus bundle between the AHB5 interconnect, the exclusive access monitor
//   and the downstream (non exclusive-aware) memory slave.
//   Signals:
//     HSEL, HADDR, HTRANS, HWRITE, HMASTER, HEXCL, HREADY
//       Address-phase signals and bus HREADY, driven by the interconnect.
//     HREADYOUT, HRESP, HEXOKAY
//       Response signals returned by the monitor to the interconnect.
//     SHSEL
//       Gated select from the monitor to the memory slave.
//     SHREADYOUT, SHRESP
//       Response signals from the memory slave.
//   Modports:
//     slave  - the monitor's view of the bundle.
//     master - the interconnect / environment view of the bundle.
interface ahb5_excl_monitor_if #(
  parameter int ADDR_W   = 32,
  parameter int MASTER_W = 2
);
  logic                HSEL;
  logic [ADDR_W-1:0]   HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [MASTER_W-1:0] HMASTER;
  logic                HEXCL;
  logic                HREADY;
  logic                HREADYOUT;
  logic                HRESP;
  logic                HEXOKAY;
  logic                SHSEL;
  logic                SHREADYOUT;
  logic                SHRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HMASTER, HEXCL, HREADY,
    input  SHREADYOUT, SHRESP,
    output HREADYOUT, HRESP, HEXOKAY, SHSEL
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HMASTER, HEXCL, HREADY,
    output SHREADYOUT, SHRESP,
    input  HREADYOUT, HRESP, HEXOKAY, SHSEL
  );
endinterface

// File: rtl/ahb5_excl_monitor.sv
// ahb5_excl_monitor
//   Slave-side AHB5 exclusive access monitor placed in front of a memory
//   slave that has no exclusive support. It keeps one reservation (valid bit
//   and granule tag) per bus master, answers HEXOKAY for successful exclusive
//   transfers and completes failed exclusive writes itself, so the memory
//   never sees them.
//   Ports:
//     HCLK     clock
//     HRESETn  asynchronous active-low reset
//     bus      ahb5_excl_monitor_if.slave: address phase in, HREADYOUT /
//              HRESP / HEXOKAY out, SHSEL out, SHREADYOUT / SHRESP in
module ahb5_excl_monitor #(
  parameter int ADDR_W   = 32,
  parameter int MASTER_W = 2,
  parameter int GRAN_LSB = 3
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb5_excl_monitor_if.slave bus
);
  localparam int NUM_M = 1 << MASTER_W;
  localparam int TAG_W = ADDR_W - GRAN_LSB;

  logic [TAG_W-1:0]    addr_tag;
  logic [MASTER_W-1:0] mst;
  logic                accept;
  logic                pass;
  logic                fail;
  logic                excl_wr_deny;
  logic                err_clr;

  logic [NUM_M-1:0]    valid_vec;
  logic [TAG_W-1:0]    tag_vec [NUM_M];

  logic                dp_act_reg;
  logic                dp_blk_reg;
  logic                dp_excl_reg;
  logic                dp_wr_reg;
  logic [MASTER_W-1:0] dp_mst_reg;

  // Byte offset within a granule and HTRANS[0] carry no information here.
  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[GRAN_LSB-1:0]};

  assign addr_tag = bus.HADDR[ADDR_W-1:GRAN_LSB];
  assign mst      = bus.HMASTER;
  assign accept   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign pass     = valid_vec[mst] & (tag_vec[mst] == addr_tag);
  assign fail     = accept & bus.HEXCL & bus.HWRITE & ~pass;

  // Deliberately not qualified by HREADY: during wait states the gate is
  // re-evaluated every cycle, so the memory never samples a doomed write.
  assign excl_wr_deny = bus.HTRANS[1] & bus.HEXCL & bus.HWRITE & ~pass;
  assign bus.SHSEL    = bus.HSEL & ~excl_wr_deny;

  // Last cycle of an exclusive read that the memory answered with ERROR.
  assign err_clr = dp_act_reg & dp_excl_reg & ~dp_wr_reg &
                   bus.SHRESP & bus.SHREADYOUT;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_entry
      logic             valid_reg;
      logic             valid_next;
      logic [TAG_W-1:0] tag_reg;
      logic [TAG_W-1:0] tag_next;
      logic             own;
      logic             tag_hit;
      logic             set_res;
      logic             clr_res;

      assign own     = (mst == MASTER_W'(gi));
      assign tag_hit = (tag_reg == addr_tag);
      assign set_res = accept & bus.HEXCL & ~bus.HWRITE & own;

      // Own exclusive write (pass or fail) consumes the reservation; a plain
      // write or a successful exclusive write kills every matching granule.
      assign clr_res = (accept & bus.HWRITE & bus.HEXCL & own) |
                       (accept & bus.HWRITE & (~bus.HEXCL | pass) & tag_hit) |
                       (err_clr & (dp_mst_reg == MASTER_W'(gi)));

      // A new reservation wins over any clear landing in the same cycle.
      always_comb begin
        valid_next = valid_reg;
        tag_next   = tag_reg;
        if (set_res) begin
          valid_next = 1'b1;
          tag_next   = addr_tag;
        end else if (clr_res) begin
          valid_next = 1'b0;
        end
      end

      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
        end else begin
          valid_reg <= valid_next;
          tag_reg   <= tag_next;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign tag_vec[gi]   = tag_reg;
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act_reg  <= 1'b0;
      dp_blk_reg  <= 1'b0;
      dp_excl_reg <= 1'b0;
      dp_wr_reg   <= 1'b0;
      dp_mst_reg  <= '0;
    end else if (bus.HREADY) begin
      dp_act_reg  <= accept;
      dp_blk_reg  <= fail;
      dp_excl_reg <= accept & bus.HEXCL;
      dp_wr_reg   <= accept & bus.HWRITE;
      dp_mst_reg  <= mst;
    end
  end

  // A blocked write is answered locally: zero-wait OKAY, no HEXOKAY.
  assign bus.HREADYOUT = dp_blk_reg ? 1'b1 : bus.SHREADYOUT;
  assign bus.HRESP     = dp_blk_reg ? 1'b0 : bus.SHRESP;
  assign bus.HEXOKAY   = dp_act_reg & dp_excl_reg & ~dp_blk_reg &
                         bus.SHREADYOUT & ~bus.SHRESP;
endmodule

// File: tb/tb_ahb5_excl_monitor.sv
// tb_ahb5_excl_monitor
//   Directed bench for ahb5_excl_monitor. A transaction-level reservation
//   model (per-master granule number plus the outcome of the pending data
//   phase) predicts the monitor outputs every cycle; directed sequences add
//   hand-computed literal expectations.
module tb_ahb5_excl_monitor;
  logic HCLK = 1'b0;
  logic HRESETn;
  bit   stall = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   slv_wr_200 = 0;

  ahb5_excl_monitor_if #(.ADDR_W(32), .MASTER_W(2)) bus ();

  ahb5_excl_monitor #(.ADDR_W(32), .MASTER_W(2), .GRAN_LSB(3)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  // Bus HREADY comes from this slave unless another slave is stalling.
  assign bus.HREADY = bus.HREADYOUT & ~stall;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {PK_NONE, PK_NORMAL, PK_LIVE, PK_DENIED} pend_t;
  bit          res_valid [4];
  int unsigned res_gran  [4];
  pend_t       pend_kind;
  bit          pend_rd;
  int          pend_mst;

  function automatic bit model_pass(input int m, input logic [31:0] a);
    return res_valid[m] && (res_gran[m] == int'(a >> 3));
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < 4; k++) begin
        res_valid[k] <= 1'b0;
        res_gran[k]  <= 0;
      end
      pend_kind <= PK_NONE;
      pend_rd   <= 1'b0;
      pend_mst  <= 0;
    end else begin
      // An exclusive read that ended in ERROR loses its reservation.
      if (pend_kind == PK_LIVE && pend_rd && bus.SHREADYOUT && bus.SHRESP)
        res_valid[pend_mst] <= 1'b0;
      if (bus.HREADY) begin
        if (bus.HSEL && bus.HTRANS[1]) begin
          if (bus.HWRITE && bus.HEXCL) begin
            if (model_pass(int'(bus.HMASTER), bus.HADDR)) begin
              for (int k = 0; k < 4; k++)
                if (res_gran[k] == int'(bus.HADDR >> 3)) res_valid[k] <= 1'b0;
              pend_kind <= PK_LIVE;
            end else begin
              pend_kind <= PK_DENIED;
            end
            res_valid[bus.HMASTER] <= 1'b0;
          end else if (bus.HWRITE) begin
            for (int k = 0; k < 4; k++)
              if (res_gran[k] == int'(bus.HADDR >> 3)) res_valid[k] <= 1'b0;
            pend_kind <= PK_NORMAL;
          end else if (bus.HEXCL) begin
            // Placed after the error clear so a fresh reservation wins.
            res_valid[bus.HMASTER] <= 1'b1;
            res_gran[bus.HMASTER]  <= int'(bus.HADDR >> 3);
            pend_kind <= PK_LIVE;
          end else begin
            pend_kind <= PK_NORMAL;
          end
          pend_rd  <= !bus.HWRITE;
          pend_mst <= int'(bus.HMASTER);
        end else begin
          pend_kind <= PK_NONE;
        end
      end
    end
  end

  // Count memory-side writes to the 0x200 granule.
  always @(posedge HCLK)
    if (HRESETn && bus.SHSEL && bus.HTRANS[1] && bus.HREADY && bus.HWRITE &&
        bus.HADDR[31:3] == 29'h40)
      slv_wr_200 <= slv_wr_200 + 1;

  // Per-cycle comparison against the model.
  always @(negedge HCLK) begin : cmp
    bit denied, e_shsel, e_rdy, e_resp, e_ok;
    denied  = (pend_kind == PK_DENIED);
    e_shsel = bus.HSEL && !(bus.HTRANS[1] && bus.HEXCL && bus.HWRITE &&
              !model_pass(int'(bus.HMASTER), bus.HADDR));
    e_rdy   = denied ? 1'b1 : bus.SHREADYOUT;
    e_resp  = denied ? 1'b0 : bus.SHRESP;
    e_ok    = (pend_kind == PK_LIVE) && bus.SHREADYOUT && !bus.SHRESP;
    chk("cyc_shsel",     bus.SHSEL,     e_shsel);
    chk("cyc_hreadyout", bus.HREADYOUT, e_rdy);
    chk("cyc_hresp",     bus.HRESP,     e_resp);
    chk("cyc_hexokay",   bus.HEXOKAY,   e_ok);
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0;
    bus.HWRITE = 1'b0; bus.HMASTER = '0; bus.HEXCL = 1'b0;
  endtask

  task automatic drive_addr(input logic [1:0] m, input logic [31:0] a, input bit wr, input bit ex);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a;
    bus.HWRITE = wr; bus.HMASTER = m; bus.HEXCL = ex;
  endtask

  // One transfer followed by idle. 'noisy' makes the memory look busy and
  // erroring during the data phase, which only a blocked transfer hides.
  task automatic xfer(input logic [1:0] m, input logic [31:0] a, input bit wr,
                      input bit ex, input bit noisy,
                      output bit a_shsel, output bit d_rdy, output bit d_resp, output bit d_ok);
    drive_addr(m, a, wr, ex);
    @(negedge HCLK); a_shsel = bus.SHSEL;
    @(posedge HCLK); #1;
    drive_idle();
    if (noisy) begin bus.SHREADYOUT = 1'b0; bus.SHRESP = 1'b1; end
    @(negedge HCLK);
    d_rdy = bus.HREADYOUT; d_resp = bus.HRESP; d_ok = bus.HEXOKAY;
    @(posedge HCLK); #1;
    bus.SHREADYOUT = 1'b1; bus.SHRESP = 1'b0;
    for (int i = 0; i < 8 && !bus.HREADY; i++) begin @(posedge HCLK); #1; end
    chk("xfer_drain", bus.HREADY, 1'b1);
    $display("xfer m=%0d addr=%h %s%s shsel=%b hreadyout=%b hresp=%b hexokay=%b",
             m, a, ex ? "X" : "", wr ? "WR" : "RD", a_shsel, d_rdy, d_resp, d_ok);
  endtask

  // Exclusive read whose data phase gets 3 wait states then a 2-cycle ERROR.
  // With 'ov', a new exclusive read is issued during the final ERROR cycle.
  task automatic err_read(input logic [1:0] m, input logic [31:0] a, input bit ov, input logic [31:0] ov_a);
    drive_addr(m, a, 1'b0, 1'b1);
    @(posedge HCLK); #1;
    drive_idle();
    bus.SHREADYOUT = 1'b0; bus.SHRESP = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("err_wait_hexokay", bus.HEXOKAY, 1'b0);
      chk("err_wait_hreadyout", bus.HREADYOUT, 1'b0);
      @(posedge HCLK); #1;
    end
    bus.SHRESP = 1'b1;
    @(negedge HCLK);
    chk("err_first_hexokay", bus.HEXOKAY, 1'b0);
    chk("err_first_hresp", bus.HRESP, 1'b1);
    @(posedge HCLK); #1;
    bus.SHREADYOUT = 1'b1;
    if (ov) drive_addr(m, ov_a, 1'b0, 1'b1);
    @(negedge HCLK);
    chk("err_last_hexokay", bus.HEXOKAY, 1'b0);
    chk("err_last_hreadyout", bus.HREADYOUT, 1'b1);
    chk("err_last_hresp", bus.HRESP, 1'b1);
    @(posedge HCLK); #1;
    bus.SHRESP = 1'b0;
    drive_idle();
    if (ov) begin
      @(negedge HCLK);
      chk("err_ov_read_hexokay", bus.HEXOKAY, 1'b1);
      @(posedge HCLK); #1;
    end
    $display("err_read m=%0d addr=%h overlap=%b", m, a, ov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit s, r, p, o;
    HRESETn = 1'b0;
    drive_idle();
    bus.HSEL = 1'b1;
    bus.SHREADYOUT = 1'b0; bus.SHRESP = 1'b1;
    @(negedge HCLK);
    chk("rst_hexokay", bus.HEXOKAY, 1'b0);
    chk("rst_hreadyout_follows", bus.HREADYOUT, 1'b0);
    chk("rst_hresp_follows", bus.HRESP, 1'b1);
    chk("rst_shsel_follows", bus.SHSEL, 1'b1);
    @(posedge HCLK); #1;
    bus.SHREADYOUT = 1'b1; bus.SHRESP = 1'b0;
    drive_idle();
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // 1: reservation and same-granule write, then a second write fails
    xfer(2'd1, 32'h100, 1'b0, 1'b1, 1'b0, s, r, p, o);
    chk("t1_rd_hexokay", o, 1'b1);
    xfer(2'd1, 32'h104, 1'b1, 1'b1, 1'b0, s, r, p, o);
    chk("t1_wr_shsel", s, 1'b1);
    chk("t1_wr_hexokay", o, 1'b1);
    xfer(2'd1, 32'h100, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t1_wr2_shsel", s, 1'b0);
    chk("t1_wr2_hreadyout", r, 1'b1);
    chk("t1_wr2_hresp", p, 1'b0);
    chk("t1_wr2_hexokay", o, 1'b0);

    // 2: another master's plain write kills the reservation
    xfer(2'd1, 32'h200, 1'b0, 1'b1, 1'b0, s, r, p, o);
    xfer(2'd2, 32'h200, 1'b1, 1'b0, 1'b0, s, r, p, o);
    chk("t2_plain_wr_shsel", s, 1'b1);
    xfer(2'd1, 32'h200, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t2_excl_wr_shsel", s, 1'b0);
    chk("t2_excl_wr_hexokay", o, 1'b0);
    chk("t2_mem_writes", slv_wr_200, 1);

    // 3: two readers, first writer wins
    xfer(2'd0, 32'h300, 1'b0, 1'b1, 1'b0, s, r, p, o);
    xfer(2'd2, 32'h300, 1'b0, 1'b1, 1'b0, s, r, p, o);
    xfer(2'd0, 32'h300, 1'b1, 1'b1, 1'b0, s, r, p, o);
    chk("t3_m0_wr_shsel", s, 1'b1);
    chk("t3_m0_wr_hexokay", o, 1'b1);
    xfer(2'd2, 32'h300, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t3_m2_wr_shsel", s, 1'b0);

    // 4: reservation moved; failed write also drops the moved one
    xfer(2'd3, 32'h400, 1'b0, 1'b1, 1'b0, s, r, p, o);
    xfer(2'd3, 32'h500, 1'b0, 1'b1, 1'b0, s, r, p, o);
    xfer(2'd3, 32'h400, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t4_wr400_shsel", s, 1'b0);
    xfer(2'd3, 32'h500, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t4_wr500_after_fail_shsel", s, 1'b0);

    // 5: error on exclusive read, overlap priority, and HREADY stall
    err_read(2'd1, 32'h600, 1'b0, 32'h0);
    xfer(2'd1, 32'h600, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t5_after_err_shsel", s, 1'b0);
    err_read(2'd1, 32'h600, 1'b1, 32'h680);
    xfer(2'd1, 32'h680, 1'b1, 1'b1, 1'b0, s, r, p, o);
    chk("t5_overlap_wr_shsel", s, 1'b1);
    chk("t5_overlap_wr_hexokay", o, 1'b1);
    xfer(2'd1, 32'h700, 1'b0, 1'b1, 1'b0, s, r, p, o);
    drive_addr(2'd1, 32'h700, 1'b1, 1'b1);
    stall = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      chk("t5_stall_shsel", bus.SHSEL, 1'b1);
      @(posedge HCLK); #1;
    end
    stall = 1'b0;
    @(negedge HCLK);
    chk("t5_accept_shsel", bus.SHSEL, 1'b1);
    @(posedge HCLK); #1;
    drive_idle();
    @(negedge HCLK);
    chk("t5_stalled_wr_hexokay", bus.HEXOKAY, 1'b1);
    @(posedge HCLK); #1;
    $display("stalled xfer m=1 addr=00000700 XWR");
    xfer(2'd1, 32'h700, 1'b1, 1'b1, 1'b1, s, r, p, o);
    chk("t5_reuse_shsel", s, 1'b0);

    // 6: reset wipes all reservations, HEXOKAY low while in reset
    for (int m = 0; m < 4; m++)
      xfer(2'(m), 32'h800 + 32'(m * 8), 1'b0, 1'b1, 1'b0, s, r, p, o);
    drive_addr(2'd0, 32'h800, 1'b0, 1'b1);
    @(posedge HCLK); #1;
    drive_idle();
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_hexokay", bus.HEXOKAY, 1'b0);
    @(negedge HCLK);
    chk("t6_rst_hexokay_neg", bus.HEXOKAY, 1'b0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    $display("reset pulse applied");
    for (int m = 0; m < 4; m++) begin
      xfer(2'(m), 32'h800 + 32'(m * 8), 1'b1, 1'b1, 1'b1, s, r, p, o);
      chk("t6_post_rst_shsel", s, 1'b0);
      chk("t6_post_rst_hexokay", o, 1'b0);
    end

    repeat (2) @(posedge HCLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
